// File: rtl/hqm_list_sel_mem_rf_pg_param.sv
// hqm_list_sel_mem_rf_pg_param: power-gated register-file with zeroing sweep on every power-up
module hqm_list_sel_mem_rf_pg_param #(
  parameter int DEPTH    = 64,
  parameter int WIDTH    = 8,
  parameter int RD_LAT   = 1,
  parameter int WAKE_CYC = 4,
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  input  logic             pwr_dn_req,
  input  logic             pwr_up_req,
  output logic             pgcb_isol_en,
  output logic             pwr_enable_b_out,
  output logic [2:0]       pwr_state,
  output logic             busy,
  output logic             access_err
);
  typedef enum logic [2:0] {INIT = 3'd0, ON = 3'd1, ISOL = 3'd2, OFF = 3'd3, WAKE = 3'd4} state_t;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [7:0] WLAST = 8'(WAKE_CYC - 1);
  state_t           r_state, w_next;
  logic [AW-1:0]    r_cnt;
  logic [7:0]       r_wcnt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_aerr, r_rerr;
  logic             w_on, w_wr_in, w_rd_in, w_we_ok, w_re_ok, w_aerr;
  logic             w_e0, w_v1, w_e1;
  logic [WIDTH-1:0] w_d0, w_d1;
  assign w_on    = r_state == ON;
  assign w_wr_in = 32'(waddr) < DEPTH;
  assign w_rd_in = 32'(raddr) < DEPTH;
  assign w_we_ok = w_on & we & w_wr_in;
  assign w_re_ok = w_on & re;
  assign w_aerr  = ((we | re) & ~w_on) | (w_on & we & ~w_wr_in);
  assign w_e0    = ~w_rd_in;
  // write-first: a same-cycle accepted write to the read address bypasses the array
  assign w_d0 = !w_rd_in ? '0 : (w_we_ok && waddr == raddr) ? wdata : r_mem[raddr];
  always_comb begin
    w_next = r_state;
    case (r_state)
      INIT:    w_next = (r_cnt == LAST) ? ON : INIT;
      ON:      w_next = pwr_dn_req ? ISOL : ON;
      ISOL:    w_next = OFF;
      OFF:     w_next = pwr_up_req ? WAKE : OFF;
      WAKE:    w_next = (r_wcnt == WLAST) ? INIT : WAKE;
      default: w_next = INIT;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == INIT && r_cnt != LAST) ? r_cnt + 1'b1 : '0;
      r_wcnt  <= (r_state == WAKE) ? r_wcnt + 1'b1 : '0;
    end
  end
  // storage is deliberately unreset; the INIT sweep is what zeroes it
  always_ff @(posedge clk) begin
    if (w_we_ok) r_mem[waddr] <= wdata;
    else if (r_state == INIT) r_mem[r_cnt] <= '0;
  end
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic             r_pv, r_pe;
      logic [WIDTH-1:0] r_pd;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pv <= 1'b0;
          r_pe <= 1'b0;
          r_pd <= '0;
        end else begin
          r_pv <= w_re_ok;
          r_pe <= w_e0;
          r_pd <= w_d0;
        end
      end
      assign w_v1 = r_pv;
      assign w_e1 = r_pe;
      assign w_d1 = r_pd;
    end else begin : g_lat1
      assign w_v1 = w_re_ok;
      assign w_e1 = w_e0;
      assign w_d1 = w_d0;
    end
  endgenerate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      r_rerr <= 1'b0;
      r_aerr <= 1'b0;
    end else begin
      rvalid <= w_v1;
      if (w_v1) rdata <= w_d1;
      r_rerr <= w_v1 & w_e1;
      r_aerr <= w_aerr;
    end
  end
  assign access_err       = r_aerr | r_rerr;
  assign pgcb_isol_en     = r_state == ISOL || r_state == OFF || r_state == WAKE;
  assign pwr_enable_b_out = r_state == OFF;
  assign pwr_state        = r_state;
  assign busy             = ~w_on;
endmodule

// File: tb/tb_hqm_list_sel_mem_rf_pg_param.sv
// tb_hqm_list_sel_mem_rf_pg_param: directed checks on a default instance and a DEPTH=48/RD_LAT=2 instance
module tb_hqm_list_sel_mem_rf_pg_param;
  logic       clk = 1'b0;
  int         n_cmp = 0, n_err = 0;
  logic       rst_a = 1'b1, we_a = 1'b0, re_a = 1'b0, dn_a = 1'b0, up_a = 1'b0;
  logic [5:0] wa_a = '0, ra_a = '0;
  logic [7:0] wd_a = '0, rd_a;
  logic       rv_a, iso_a, pb_a, busy_a, err_a;
  logic [2:0] st_a;
  logic       rst_b = 1'b1, we_b = 1'b0, re_b = 1'b0, dn_b = 1'b0, up_b = 1'b0;
  logic [5:0] wa_b = '0, ra_b = '0;
  logic [7:0] wd_b = '0, rd_b;
  logic       rv_b, iso_b, pb_b, busy_b, err_b;
  logic [2:0] st_b;
  always #5 clk = ~clk;
  hqm_list_sel_mem_rf_pg_param u_a (
    .clk(clk), .rst(rst_a), .we(we_a), .waddr(wa_a), .wdata(wd_a), .re(re_a), .raddr(ra_a),
    .rdata(rd_a), .rvalid(rv_a), .pwr_dn_req(dn_a), .pwr_up_req(up_a), .pgcb_isol_en(iso_a),
    .pwr_enable_b_out(pb_a), .pwr_state(st_a), .busy(busy_a), .access_err(err_a));
  hqm_list_sel_mem_rf_pg_param #(.DEPTH(48), .RD_LAT(2)) u_b (
    .clk(clk), .rst(rst_b), .we(we_b), .waddr(wa_b), .wdata(wd_b), .re(re_b), .raddr(ra_b),
    .rdata(rd_b), .rvalid(rv_b), .pwr_dn_req(dn_b), .pwr_up_req(up_b), .pgcb_isol_en(iso_b),
    .pwr_enable_b_out(pb_b), .pwr_state(st_b), .busy(busy_b), .access_err(err_b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    tick(2);
    chk("a_rst_state", st_a, 0); chk("a_rst_busy", busy_a, 1); chk("a_rst_rvalid", rv_a, 0);
    chk("a_rst_rdata", rd_a, 0); chk("a_rst_err", err_a, 0); chk("a_rst_isol", iso_a, 0);
    chk("a_rst_pwrb", pb_a, 0);
    rst_a = 1'b0;
    tick(63);
    chk("a_init_busy63", busy_a, 1); chk("a_init_state63", st_a, 0);
    tick();
    chk("a_on_state", st_a, 1); chk("a_on_busy", busy_a, 0);
    re_a = 1'b1; ra_a = 6'd5; tick(); re_a = 1'b0;
    chk("a_rd5_valid", rv_a, 1); chk("a_rd5_data", rd_a, 8'h00);
    tick(); chk("a_rd5_valid_drop", rv_a, 0);
    we_a = 1'b1; wa_a = 6'd3; wd_a = 8'hA5; tick(); we_a = 1'b0;
    re_a = 1'b1; ra_a = 6'd3; tick(); re_a = 1'b0;
    chk("a_rd3_valid", rv_a, 1); chk("a_rd3_data", rd_a, 8'hA5);
    tick(); chk("a_hold_valid", rv_a, 0); chk("a_hold_data", rd_a, 8'hA5);
    we_a = 1'b1; wa_a = 6'd7; wd_a = 8'h3C; re_a = 1'b1; ra_a = 6'd7; tick(); we_a = 1'b0; re_a = 1'b0;
    chk("a_coll_valid", rv_a, 1); chk("a_coll_data", rd_a, 8'h3C);
    re_a = 1'b1; ra_a = 6'd3; dn_a = 1'b1; tick(); re_a = 1'b0; dn_a = 1'b0;
    chk("a_dn_rvalid", rv_a, 1); chk("a_dn_rdata", rd_a, 8'hA5); chk("a_isol_state", st_a, 2);
    chk("a_isol_en", iso_a, 1); chk("a_isol_pwrb", pb_a, 0);
    tick();
    chk("a_off_state", st_a, 3); chk("a_off_isol", iso_a, 1); chk("a_off_pwrb", pb_a, 1);
    we_a = 1'b1; wa_a = 6'd3; wd_a = 8'hFF; tick(); we_a = 1'b0;
    chk("a_rej_err", err_a, 1); chk("a_rej_state", st_a, 3);
    tick(); chk("a_rej_err_pulse", err_a, 0);
    up_a = 1'b1; tick(); up_a = 1'b0;
    chk("a_wake_state", st_a, 4); chk("a_wake_pwrb", pb_a, 0); chk("a_wake_isol", iso_a, 1);
    tick(3); chk("a_wake4_state", st_a, 4);
    tick(); chk("a_reinit_state", st_a, 0); chk("a_reinit_isol", iso_a, 0);
    tick(63); chk("a_reinit63", st_a, 0);
    tick(); chk("a_reon_state", st_a, 1);
    re_a = 1'b1; ra_a = 6'd3; tick(); re_a = 1'b0;
    chk("a_post_wake_valid", rv_a, 1); chk("a_post_wake_data", rd_a, 8'h00);
    rst_b = 1'b0;
    tick(47); chk("b_init47", st_b, 0);
    tick(); chk("b_on_state", st_b, 1);
    for (int i = 0; i < 48; i++) begin
      we_b = 1'b1; wa_b = 6'(i); wd_b = 8'(i + 1); tick();
    end
    we_b = 1'b0;
    for (int j = 0; j <= 48; j++) begin
      re_b = j < 48; ra_b = 6'(j); tick();
      if (j >= 1) begin
        chk($sformatf("b_stream_v%0d", j - 1), rv_b, 1);
        chk($sformatf("b_stream_d%0d", j - 1), rd_b, 32'(j));
      end
    end
    re_b = 1'b1; ra_b = 6'd50; tick(); re_b = 1'b0;
    chk("b_oor_lat1_valid", rv_b, 0);
    tick();
    chk("b_oor_valid", rv_b, 1); chk("b_oor_data", rd_b, 0); chk("b_oor_err", err_b, 1);
    dn_b = 1'b1; tick(); dn_b = 1'b0; tick();
    chk("b_off_state", st_b, 3);
    up_b = 1'b1; tick(); up_b = 1'b0; tick();
    chk("b_wake2_state", st_b, 4);
    rst_b = 1'b1; #1;
    chk("b_mrst_state", st_b, 0); chk("b_mrst_busy", busy_b, 1); chk("b_mrst_isol", iso_b, 0);
    chk("b_mrst_pwrb", pb_b, 0); chk("b_mrst_rvalid", rv_b, 0); chk("b_mrst_rdata", rd_b, 0);
    chk("b_mrst_err", err_b, 0);
    tick(); rst_b = 1'b0;
    tick(47); chk("b_resweep47", st_b, 0);
    tick(); chk("b_reon_state", st_b, 1);
    re_b = 1'b1; ra_b = 6'd10; tick(); re_b = 1'b0; tick();
    chk("b_post_valid", rv_b, 1); chk("b_post_data", rd_b, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
